fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Sequential program-counter and instruction-fetch stage that sits directly upstream of the control unit.
- Owns the PC register and fetches each instruction from instruction memory over a req/valid handshake.
- Holds the fetched word in an instruction register and presents OpCode/FunctCode and immediate fields to decode.
- On instruction commit, updates PC from the control unit's NPCSel (sequential, branch, jump, register-jump).

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; must be word aligned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- NPCSel  input  2  next-PC select from control unit: 00 PC+4, 01 branch, 10 jump, 11 register jump.
- RegRs  input  32  rs register value; target for NPCSel=11.
- Advance  input  1  one-cycle pulse from downstream: current instruction complete, commit next PC.
- IMemReq  output  1  fetch request.
- IMemAddr  output  32  fetch address (word aligned).
- IMemRdata  input  32  fetched instruction word.
- IMemValid  input  1  IMemRdata valid this cycle.
- Instr  output  32  instruction register.
- InstrValid  output  1  Instr holds a valid, not-yet-committed instruction.
- OpCode  output  6  Instr[31:26].
- FunctCode  output  6  Instr[5:0].
- Imm16  output  16  Instr[15:0].
- PC  output  32  address of Instr.
- PCPlus4  output  32  PC+4; link value for jal/jalr.
- AddrErr  output  1  sticky misaligned-target flag.
- Retired  output  CNT_W  count of committed instructions.

Behaviour:
- Reset (async, Rst_n=0):
  - State=START; PC=RESET_PC; Instr=0.
  - InstrValid=0, IMemReq=0, AddrErr=0, Retired=0.
  - IMemAddr=RESET_PC.
- FSM states:
  - START: one cycle after reset release, then FETCH.
  - FETCH: IMemReq=1 with IMemAddr=PC, both held stable until IMemValid is sampled 1. On that edge: Instr<=IMemRdata, InstrValid<=1, IMemReq<=0, go EXEC.
  - EXEC: hold Instr/PC stable. On Advance=1: compute next PC, Retired<=Retired+1 (wraps modulo 2^CNT_W), InstrValid<=0.
    - If next PC[1:0]!=0: set AddrErr=1, go HALT, PC unchanged.
    - Otherwise PC<=next PC, go FETCH.
  - HALT: terminal until reset. IMemReq=0, InstrValid=0, Advance ignored.
- Next-PC arithmetic (all modulo 2^32):
  - 00: PC+4.
  - 01: PC+4 + (signext(Imm16)<<2).
  - 10: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - 11: RegRs.
  - Branch taken/not-taken is already folded into NPCSel; this block does not evaluate Zero.
- Misalignment can only arise via NPCSel=11 (jr/jalr with RegRs[1:0]!=0).
- Fetch latency ≥1 cycle after IMemReq rises; minimum instruction period is START→FETCH(1)→EXEC(1).
- Ignored inputs:
  - IMemValid outside FETCH, including a late response arriving after a mid-fetch reset.
  - Advance outside EXEC.
- PC wraps 32'hFFFF_FFFC → 0 with no error.
- PCPlus4 is combinational from PC; OpCode/FunctCode/Imm16 are combinational slices of Instr.
- NPCSel is sampled only on the Advance edge; X on NPCSel at other times has no effect.

Decomposition:
- Shared package (cpu_defs):
  - NPCSel encodings NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11.
  - FSM state encodings START/FETCH/EXEC/HALT.
  - Default RESET_PC constant.
- Sub-module npc_calc: purely combinational. Inputs PC, Instr, RegRs, NPCSel; outputs NextPC and Misaligned. Reused by any future pipelined variant.

Test Plan:
- Reset release, IMemValid returned 2 cycles after IMemReq with 32'h2008_0005 → IMemAddr=32'h3000 held stable; Instr=32'h2008_0005, OpCode=6'b001000, InstrValid=1; PCPlus4=32'h3004.
- Advance with NPCSel=00 at PC=32'h3000 → next fetch IMemAddr=32'h3004; Retired=1.
- PC=32'h3010, Instr Imm16=16'hFFFC, Advance with NPCSel=01 → PC=32'h3004 (backward branch, negative offset).
- PC=32'h3020, Instr=32'h0800_0C10, Advance with NPCSel=10 → PC=32'h0000_3040.
- Advance with NPCSel=11 and RegRs=32'h0000_3102 → AddrErr=1, state HALT, IMemReq stays 0, PC unchanged; Rst_n pulse clears AddrErr and PC=32'h3000.
- Assert Rst_n=0 mid-FETCH, then IMemValid=1 during START → Instr stays 0, InstrValid=0; fetch restarts at 32'h3000.

Source files
------------

// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs : shared encodings for the fetch/PC stage and its neighbours
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_defs;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

`default_nettype wire

// File: rtl/npc_calc.sv
// ---------------------------------------------------------------------------
// npc_calc : combinational next-PC selection and alignment check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module npc_calc
  import cpu_defs::*;
(
  input  logic [31:0] PC,
  input  logic [31:0] Instr,
  input  logic [31:0] RegRs,
  input  logic [1:0]  NPCSel,
  output logic [31:0] NextPC,
  output logic        Misaligned
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic        unused_opcode;

  assign pc_plus4  = PC + 32'd4;
  assign br_offset = {{14{Instr[15]}}, Instr[15:0], 2'b00};
  // The opcode field plays no part in target arithmetic.
  assign unused_opcode = ^Instr[31:26];

  always_comb begin
    NextPC = pc_plus4;
    case (NPCSel)
      NPC_SEQ: NextPC = pc_plus4;
      NPC_BR:  NextPC = pc_plus4 + br_offset;
      NPC_J:   NextPC = {pc_plus4[31:28], Instr[25:0], 2'b00};
      NPC_JR:  NextPC = RegRs;
      default: NextPC = pc_plus4;
    endcase
  end

  assign Misaligned = |NextPC[1:0];

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit : PC register, instruction fetch handshake and instruction reg
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_pc_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [1:0]       NPCSel,
  input  logic [31:0]      RegRs,
  input  logic             Advance,
  output logic             IMemReq,
  output logic [31:0]      IMemAddr,
  input  logic [31:0]      IMemRdata,
  input  logic             IMemValid,
  output logic [31:0]      Instr,
  output logic             InstrValid,
  output logic [5:0]       OpCode,
  output logic [5:0]       FunctCode,
  output logic [15:0]      Imm16,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             AddrErr,
  output logic [CNT_W-1:0] Retired
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             addr_err_q, addr_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [31:0]      next_pc;
  logic             next_misaligned;

  npc_calc u_npc_calc (
    .PC         (pc_q),
    .Instr      (instr_q),
    .RegRs      (RegRs),
    .NPCSel     (NPCSel),
    .NextPC     (next_pc),
    .Misaligned (next_misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    addr_err_d    = addr_err_q;
    retired_d     = retired_q;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        if (IMemValid) begin
          instr_d       = IMemRdata;
          instr_valid_d = 1'b1;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (Advance) begin
          retired_d     = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
          instr_valid_d = 1'b0;
          // A misaligned target freezes the PC at the offending instruction.
          if (next_misaligned) begin
            addr_err_d = 1'b1;
            state_d    = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_START;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
      retired_q     <= retired_d;
    end
  end

  assign IMemReq    = (state_q == ST_FETCH);
  assign IMemAddr   = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = instr_valid_q;
  assign OpCode     = instr_q[31:26];
  assign FunctCode  = instr_q[5:0];
  assign Imm16      = instr_q[15:0];
  assign PC         = pc_q;
  assign PCPlus4    = pc_q + 32'd4;
  assign AddrErr    = addr_err_q;
  assign Retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit : directed + randomized self-checking bench for fetch_pc_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_pc_unit;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [1:0]  NPCSel;
  logic [31:0] RegRs;
  logic        Advance;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemRdata;
  logic        IMemValid;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [5:0]  OpCode;
  logic [5:0]  FunctCode;
  logic [15:0] Imm16;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        AddrErr;
  logic [31:0] Retired;

  fetch_pc_unit #(.RESET_PC(RPC), .CNT_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .NPCSel(NPCSel), .RegRs(RegRs), .Advance(Advance),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRdata(IMemRdata), .IMemValid(IMemValid),
    .Instr(Instr), .InstrValid(InstrValid), .OpCode(OpCode), .FunctCode(FunctCode),
    .Imm16(Imm16), .PC(PC), .PCPlus4(PCPlus4), .AddrErr(AddrErr), .Retired(Retired)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;
  logic        m_valid;
  logic        m_err;
  logic        m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [1:0] sel, input logic [31:0] pc,
                                           input logic [31:0] ins, input logic [31:0] rs);
    logic [31:0] seq;
    logic signed [15:0] imm;
    int off;
    seq = pc + 32'd4;
    imm = ins[15:0];
    off = int'(imm) * 4;
    case (sel)
      2'd0:    return seq;
      2'd1:    return seq + 32'(off);
      2'd2:    return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      default: return rs;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".pc"},      PC,                      m_pc);
    chk({tag, ".addr"},    IMemAddr,                m_pc);
    chk({tag, ".pc4"},     PCPlus4,                 m_pc + 32'd4);
    chk({tag, ".instr"},   Instr,                   m_instr);
    chk({tag, ".opcode"},  32'(OpCode),             m_instr / 32'h0400_0000);
    chk({tag, ".funct"},   32'(FunctCode),          m_instr % 32'd64);
    chk({tag, ".imm"},     32'(Imm16),              m_instr % 32'h1_0000);
    chk({tag, ".ivalid"},  32'(InstrValid),         32'(m_valid));
    chk({tag, ".err"},     32'(AddrErr),            32'(m_err));
    chk({tag, ".retired"}, Retired,                 m_retired);
  endtask

  task automatic model_reset();
    m_pc = RPC; m_instr = 32'd0; m_retired = 32'd0;
    m_valid = 1'b0; m_err = 1'b0; m_halt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    chk("reset.req", 32'(IMemReq), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("start.req", 32'(IMemReq), 32'd0);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!IMemReq && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, ".req_seen"}, 32'(IMemReq), 32'd1);
  endtask

  // Serve one fetch with the given latency; optionally poke Advance while waiting.
  task automatic fetch(input logic [31:0] word, input int lat, input bit poke_adv);
    wait_req("fetch");
    chk("fetch.addr", IMemAddr, m_pc);
    for (int i = 1; i < lat; i++) begin
      Advance = poke_adv;
      NPCSel  = 2'($urandom);
      @(negedge Clk);
      Advance = 1'b0;
      chk("fetch.hold_req", 32'(IMemReq), 32'd1);
      chk("fetch.hold_addr", IMemAddr, m_pc);
      chk("fetch.hold_ret", Retired, m_retired);
    end
    IMemRdata = word;
    IMemValid = 1'b1;
    @(negedge Clk);
    IMemValid = 1'b0;
    IMemRdata = $urandom;
    m_instr = word;
    m_valid = 1'b1;
    check_all("fetched");
    chk("fetched.req", 32'(IMemReq), 32'd0);
  endtask

  task automatic commit(input logic [1:0] sel, input logic [31:0] rs);
    logic [31:0] nxt;
    NPCSel  = sel;
    RegRs   = rs;
    Advance = 1'b1;
    @(negedge Clk);
    Advance = 1'b0;
    NPCSel  = 2'($urandom);
    RegRs   = $urandom;
    nxt = ref_next(sel, m_pc, m_instr, rs);
    m_retired = m_retired + 32'd1;
    m_valid = 1'b0;
    if (nxt % 32'd4 != 32'd0) begin
      m_err = 1'b1;
      m_halt = 1'b1;
    end else begin
      m_pc = nxt;
    end
    check_all("commit");
    chk("commit.req", 32'(IMemReq), 32'(!m_halt));
  endtask

  initial begin
    int n;
    Rst_n = 1'b1; NPCSel = 2'd0; RegRs = 32'd0; Advance = 1'b0;
    IMemRdata = 32'd0; IMemValid = 1'b0;
    model_reset();

    do_reset();
    fetch(32'h2008_0005, 2, 1'b1);
    chk("first.opcode", 32'(OpCode), 32'h8);
    chk("first.pc4", PCPlus4, 32'h3004);
    commit(2'b00, 32'd0);
    wait_req("seq");
    chk("seq.addr", IMemAddr, 32'h3004);
    chk("seq.retired", Retired, 32'd1);

    n = 0;
    while (m_pc != 32'h3010 && n < 16) begin
      fetch(32'h0000_0000, 1, 1'b0);
      commit(2'b00, 32'd0);
      n++;
    end
    fetch(32'h1000_FFFC, 1, 1'b0);
    commit(2'b01, 32'd0);
    chk("branch.back", PC, 32'h3004);

    n = 0;
    while (m_pc != 32'h3020 && n < 16) begin
      fetch(32'h0000_0000, 1, 1'b0);
      commit(2'b00, 32'd0);
      n++;
    end
    fetch(32'h0800_0C10, 3, 1'b1);
    commit(2'b10, 32'd0);
    chk("jump.pc", PC, 32'h0000_3040);

    // Randomized instruction stream; all targets kept word aligned.
    for (int k = 0; k < 40; k++) begin
      fetch($urandom, int'($urandom_range(1, 3)), 1'($urandom));
      n = int'($urandom_range(0, 2));
      for (int j = 0; j < n; j++) begin
        IMemValid = 1'($urandom);
        IMemRdata = $urandom;
        @(negedge Clk);
        IMemValid = 1'b0;
        chk("exec.instr_hold", Instr, m_instr);
        chk("exec.ivalid", 32'(InstrValid), 32'd1);
      end
      commit(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC);
    end

    // PC wrap through the top of the address space.
    fetch($urandom, 1, 1'b0);
    commit(2'b11, 32'hFFFF_FFFC);
    fetch(32'h0000_0000, 2, 1'b0);
    commit(2'b00, 32'd0);
    chk("wrap.pc", PC, 32'd0);
    chk("wrap.err", 32'(AddrErr), 32'd0);

    // Misaligned register jump halts the unit.
    fetch(32'h0000_0008, 1, 1'b0);
    commit(2'b11, 32'h0000_3102);
    chk("halt.err", 32'(AddrErr), 32'd1);
    for (int j = 0; j < 4; j++) begin
      Advance = 1'b1;
      IMemValid = 1'b1;
      IMemRdata = $urandom;
      @(negedge Clk);
      chk("halt.req", 32'(IMemReq), 32'd0);
      check_all("halt");
    end
    Advance = 1'b0;
    IMemValid = 1'b0;
    do_reset();
    chk("post_halt.err", 32'(AddrErr), 32'd0);
    chk("post_halt.pc", PC, 32'h3000);

    // Reset in the middle of a fetch, with a stale response arriving in START.
    wait_req("midfetch");
    Rst_n = 1'b0;
    IMemValid = 1'b1;
    IMemRdata = 32'hDEAD_BEEF;
    model_reset();
    #1;
    check_all("mid.reset");
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    IMemValid = 1'b0;
    check_all("mid.start");
    chk("mid.req", 32'(IMemReq), 32'd1);
    fetch(32'h2008_0005, 2, 1'b0);
    commit(2'b00, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
